sdio_crc16_rx: RTL and testbench
================================

SDIO_CRC16_RX -- requirements
Module: sdio_crc16_rx

Interface
REQ-001 SHALL have parameter POLYNOMIAL, default 16'h1021, CRC16 generator polynomial with the x^16 term dropped.
REQ-002 SHALL have parameter SEED, default 16'h0000, CRC register value at block start.
REQ-003 SHALL have parameter TIMEOUT, default 16'd1024, maximum number of cycles to wait for the start bit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge (SD clock domain).
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to receive one block.
REQ-007 SHALL have port abort, input, 1 bit: cancels a receive in progress.
REQ-008 SHALL have port block_size, input, 10 bits: bytes per block; 0 means 512.
REQ-009 SHALL have port sd_data, input, 1 bit: serial data line (DAT0), sampled every cycle.
REQ-010 SHALL have port data_byte, output, 8 bits: last assembled byte, MSB first on the line.
REQ-011 SHALL have port data_stb, output, 1 bit: one-cycle pulse marking data_byte valid.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking block complete.
REQ-014 SHALL have port crc_ok, output, 1 bit: status flag, held until the next accepted start.
REQ-015 SHALL have port crc_err, output, 1 bit: status flag, held until the next accepted start.
REQ-016 SHALL have port end_err, output, 1 bit: status flag, held until the next accepted start.
REQ-017 SHALL have port timeout_err, output, 1 bit: status flag, held until the next accepted start.
REQ-018 SHALL have port crc_calc, output, 16 bits: running computed CRC.

Function
REQ-019 SHALL implement the states IDLE, WAIT_START, DATA, CRC, END.
REQ-020 SHALL, in IDLE, when start=1: latch block_size, set crc_calc=SEED, clear all status flags, clear the timeout counter, and go to WAIT_START; start SHALL be ignored in every other state.
REQ-021 SHALL, in WAIT_START, go to DATA on the first sampled sd_data=0 (start bit); the start bit SHALL NOT enter the CRC.
REQ-022 SHALL, in WAIT_START, increment the timeout counter each cycle that sd_data=1.
REQ-023 SHALL, when the timeout counter reaches TIMEOUT, pulse done, set timeout_err=1, and go to IDLE.
REQ-024 SHALL, in DATA, shift each sampled bit into a byte shift register, MSB first.
REQ-025 SHALL, in DATA, update the CRC for each bit b: fb=b^crc[15]; crc_next={crc[14:0],1'b0} ^ (fb ? POLYNOMIAL : 0).
REQ-026 SHALL, on the cycle after the 8th bit of a byte is sampled, present the byte on data_byte with data_stb=1 for exactly one cycle.
REQ-027 SHALL, after block_size*8 data bits (4096 when block_size=0), go to CRC; the final data byte's strobe SHALL occur in the first CRC-state cycle.
REQ-028 SHALL, in CRC, shift 16 received bits, MSB first, into a received-CRC register, with crc_calc frozen.
REQ-029 SHALL, in END, sample one bit as the end bit, then go to IDLE; done SHALL pulse on the cycle after the end bit is sampled.
REQ-030 SHALL set status at done: crc_ok=(received CRC==crc_calc)&&(end bit==1); crc_err=(received CRC!=crc_calc); end_err=(end bit==0).
REQ-031 SHALL keep crc_ok, crc_err, end_err and timeout_err mutually consistent: crc_ok=1 implies every other flag is 0.
REQ-032 SHALL, when abort=1 in any non-IDLE state, go to IDLE next cycle with no done pulse, no data_stb, and flags left cleared; abort SHALL take priority over all other transitions in the same cycle.
REQ-033 SHALL use a bit counter wide enough for 4096 data bits; the byte count SHALL never wrap inside a block.
REQ-034 SHALL ignore sd_data in IDLE.

Reset
REQ-035 SHALL, when rst_n=0 at a rising edge, force: state=IDLE; busy=0; done=0; data_stb=0; data_byte=8'h00; crc_calc=SEED; all status flags=0; all counters=0.
REQ-036 SHALL, when reset is asserted mid-block, discard the block with no done pulse.

Verification
REQ-037 SHALL cover: block_size=0, start bit, 512 bytes of 8'hFF, CRC 16'h7FA1, end bit 1 -> 512 data_stb pulses each 8'hFF, crc_calc=16'h7FA1, done with crc_ok=1.
REQ-038 SHALL cover: block_size=1, byte 8'h00, CRC 16'h0000, end bit 1 -> one data_stb with data_byte=8'h00, then crc_ok=1.
REQ-039 SHALL cover: the REQ-037 stream with one data bit flipped -> done with crc_err=1 and crc_ok=0.
REQ-040 SHALL cover: a valid block with end bit 0 -> done with end_err=1, crc_err=0, crc_ok=0.
REQ-041 SHALL cover: start, then sd_data held at 1 -> done exactly TIMEOUT cycles after entering WAIT_START, with timeout_err=1.
REQ-042 SHALL cover: abort, and separately rst_n=0, at byte 100 of 512 -> IDLE next cycle with no done pulse; a following valid block is received with crc_ok=1.

Source files
------------

// File: rtl/sdio_crc16_rx.sv
// SDIO single-line data block receiver: start bit, block_size bytes, CRC16, end bit.
// Bytes strobe one cycle after their last bit; done one cycle after the end bit; no backpressure.
module sdio_crc16_rx #(
  parameter logic [15:0] POLYNOMIAL = 16'h1021,
  parameter logic [15:0] SEED       = 16'h0000,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  block_size,
  input  logic        sd_data,
  output logic [7:0]  data_byte,
  output logic        data_stb,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        end_err,
  output logic        timeout_err,
  output logic [15:0] crc_calc
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_CRC        = 3'd3;
  localparam logic [2:0] S_END        = 3'd4;

  logic [2:0]  state;
  logic [12:0] nbits;    // total data bits in the block, up to 4096
  logic [12:0] bitcnt;
  logic [6:0]  sreg;
  logic [15:0] rx_crc;
  logic [3:0]  ccnt;
  logic [15:0] tcnt;
  logic        fb;
  logic [15:0] crc_next;

  always_comb begin
    fb       = sd_data ^ crc_calc[15];
    crc_next = {crc_calc[14:0], 1'b0} ^ (fb ? POLYNOMIAL : 16'h0000);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      nbits       <= '0;
      bitcnt      <= '0;
      sreg        <= '0;
      rx_crc      <= '0;
      ccnt        <= '0;
      tcnt        <= '0;
      data_byte   <= 8'h00;
      data_stb    <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      end_err     <= 1'b0;
      timeout_err <= 1'b0;
      crc_calc    <= SEED;
    end else begin
      data_stb <= 1'b0;
      done     <= 1'b0;
      // Abort wins over every transition, including a pending byte strobe or done.
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              nbits       <= (block_size == 10'd0) ? 13'd4096 : {block_size, 3'b000};
              crc_calc    <= SEED;
              crc_ok      <= 1'b0;
              crc_err     <= 1'b0;
              end_err     <= 1'b0;
              timeout_err <= 1'b0;
              tcnt        <= '0;
              bitcnt      <= '0;
              ccnt        <= '0;
              state       <= S_WAIT_START;
            end
          end
          S_WAIT_START: begin
            if (!sd_data) begin
              state <= S_DATA;
            end else begin
              tcnt <= tcnt + 16'd1;
              if (tcnt == TIMEOUT - 16'd1) begin
                done        <= 1'b1;
                timeout_err <= 1'b1;
                state       <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            sreg     <= {sreg[5:0], sd_data};
            crc_calc <= crc_next;
            bitcnt   <= bitcnt + 13'd1;
            if (bitcnt[2:0] == 3'd7) begin
              data_byte <= {sreg, sd_data};
              data_stb  <= 1'b1;
            end
            if (bitcnt == nbits - 13'd1)
              state <= S_CRC;
          end
          S_CRC: begin
            rx_crc <= {rx_crc[14:0], sd_data};
            ccnt   <= ccnt + 4'd1;
            if (ccnt == 4'd15)
              state <= S_END;
          end
          S_END: begin
            done    <= 1'b1;
            crc_ok  <= (rx_crc == crc_calc) && sd_data;
            crc_err <= (rx_crc != crc_calc);
            end_err <= !sd_data;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdio_crc16_rx.sv
// Directed bench for sdio_crc16_rx: reset, good/bad blocks, timeout, abort and mid-block reset.
module tb_sdio_crc16_rx;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, sd_data;
  logic [9:0]  block_size;
  logic [7:0]  data_byte;
  logic        data_stb, busy, done, crc_ok, crc_err, end_err, timeout_err;
  logic [15:0] crc_calc;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] stb_q[$];

  sdio_crc16_rx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .block_size(block_size), .sd_data(sd_data), .data_byte(data_byte),
    .data_stb(data_stb), .busy(busy), .done(done), .crc_ok(crc_ok),
    .crc_err(crc_err), .end_err(end_err), .timeout_err(timeout_err),
    .crc_calc(crc_calc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (data_stb) stb_q.push_back(data_byte);
    if (done) done_cnt++;
  endtask

  task automatic send_bit(input logic b);
    sd_data = b;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic begin_block(input logic [9:0] bs);
    stb_q.delete();
    done_cnt   = 0;
    block_size = bs;
    sd_data    = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_block(input logic [9:0] bs, input int nbytes, input logic [7:0] fill,
                            input int flip_idx, input logic [15:0] crc, input logic endb);
    logic [7:0] v;
    begin_block(bs);
    send_bit(1'b0);
    for (int i = 0; i < nbytes; i++) begin
      v = fill;
      if (i == flip_idx) v[3] = ~v[3];
      send_byte(v);
    end
    send_byte(crc[15:8]);
    send_byte(crc[7:0]);
    send_bit(endb);
    sd_data = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; block_size = 10'd0; sd_data = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || data_stb !== 1'b0) begin failures++; $display("FAIL reset_pulses done=%b stb=%b exp=0/0", done, data_stb); end
    checks++; if (data_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", data_byte); end
    checks++; if (crc_calc !== 16'h0000) begin failures++; $display("FAIL reset_crc got=%h exp=0000", crc_calc); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {crc_ok, crc_err, end_err, timeout_err}); end
    rst_n = 1'b1;
    sd_data = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_ignores_data busy=%b exp=0", busy); end
    sd_data = 1'b1;
  endtask

  task automatic test_single_zero();
    send_block(10'd1, 1, 8'h00, -1, 16'h0000, 1'b1);
    checks++; if (stb_q.size() != 1) begin failures++; $display("FAIL zero_stb_count got=%0d exp=1", stb_q.size()); end
    else begin
      checks++; if (stb_q[0] !== 8'h00) begin failures++; $display("FAIL zero_byte got=%h exp=00", stb_q[0]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b1000) begin failures++;
      $display("FAIL zero_flags got=%b exp=1000", {crc_ok, crc_err, end_err, timeout_err}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
  endtask

  // 0xFF alone under x^16+x^12+x^5+1 from zero is 0x1EF0; a stray start mid-block must not restart it.
  task automatic test_single_ff_start_ignored();
    begin_block(10'd1);
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    start = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    for (int i = 2; i >= 0; i--) send_bit(1'b1);
    send_byte(8'h1E);
    send_byte(8'hF0);
    send_bit(1'b1);
    sd_data = 1'b1;
    tick();
    checks++; if (crc_calc !== 16'h1EF0) begin failures++; $display("FAIL ff_crc got=%h exp=1EF0", crc_calc); end
    checks++; if (stb_q.size() != 1 || stb_q[0] !== 8'hFF) begin failures++;
      $display("FAIL ff_stb count=%0d exp=1 of FF", stb_q.size()); end
    checks++; if (crc_ok !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL ff_ok crc_ok=%b done=%0d exp=1/1", crc_ok, done_cnt); end
  endtask

  task automatic test_full_block();
    int bad;
    send_block(10'd0, 512, 8'hFF, -1, 16'h7FA1, 1'b1);
    bad = 0;
    foreach (stb_q[i]) if (stb_q[i] !== 8'hFF) bad++;
    checks++; if (stb_q.size() != 512) begin failures++; $display("FAIL full_stb_count got=%0d exp=512", stb_q.size()); end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_bytes non_ff=%0d exp=0", bad); end
    checks++; if (crc_calc !== 16'h7FA1) begin failures++; $display("FAIL full_crc got=%h exp=7FA1", crc_calc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b1000) begin failures++;
      $display("FAIL full_flags got=%b exp=1000", {crc_ok, crc_err, end_err, timeout_err}); end
  endtask

  task automatic test_crc_error();
    send_block(10'd0, 512, 8'hFF, 37, 16'h7FA1, 1'b1);
    checks++; if (stb_q.size() != 512) begin failures++; $display("FAIL crcerr_stb_count got=%0d exp=512", stb_q.size()); end
    checks++; if (stb_q.size() > 37 && stb_q[37] !== 8'hF7) begin failures++; $display("FAIL crcerr_byte37 got=%h exp=F7", stb_q[37]); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b0100 || done_cnt != 1) begin failures++;
      $display("FAIL crcerr_flags got=%b done=%0d exp=0100/1", {crc_ok, crc_err, end_err, timeout_err}, done_cnt); end
  endtask

  task automatic test_end_error();
    send_block(10'd1, 1, 8'h00, -1, 16'h0000, 1'b0);
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b0010 || done_cnt != 1) begin failures++;
      $display("FAIL enderr_flags got=%b done=%0d exp=0010/1", {crc_ok, crc_err, end_err, timeout_err}, done_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    begin_block(10'd1);
    sd_data = 1'b1;
    n = 0;
    while (n < 2000) begin
      tick();
      n++;
      if (done) break;
    end
    checks++; if (n != 1024) begin failures++; $display("FAIL timeout_cycles got=%0d exp=1024", n); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b0001) begin failures++;
      $display("FAIL timeout_flags got=%b exp=0001", {crc_ok, crc_err, end_err, timeout_err}); end
    tick();
    checks++; if (busy !== 1'b0 || done_cnt != 1) begin failures++; $display("FAIL timeout_idle busy=%b done=%0d exp=0/1", busy, done_cnt); end
  endtask

  // Interrupt on the 8th bit of byte 101, so a strobe would otherwise be due.
  task automatic test_abort();
    begin_block(10'd0);
    send_bit(1'b0);
    for (int i = 0; i < 100; i++) send_byte(8'hFF);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (40) send_bit(1'b1);
    checks++; if (stb_q.size() != 100 || done_cnt != 0) begin failures++;
      $display("FAIL abort_quiet stb=%0d done=%0d exp=100/0", stb_q.size(), done_cnt); end
    checks++; if ({crc_ok, crc_err, end_err, timeout_err} !== 4'b0000) begin failures++;
      $display("FAIL abort_flags got=%b exp=0000", {crc_ok, crc_err, end_err, timeout_err}); end
    send_block(10'd1, 1, 8'h00, -1, 16'h0000, 1'b1);
    checks++; if (crc_ok !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL abort_recover crc_ok=%b done=%0d exp=1/1", crc_ok, done_cnt); end
  endtask

  task automatic test_reset_mid_block();
    begin_block(10'd0);
    send_bit(1'b0);
    for (int i = 0; i < 100; i++) send_byte(8'hFF);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst_n = 1'b0;
    send_bit(1'b1);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || data_stb !== 1'b0) begin failures++; $display("FAIL rstmid_idle busy=%b stb=%b exp=0/0", busy, data_stb); end
    checks++; if (data_byte !== 8'h00 || crc_calc !== 16'h0000) begin failures++;
      $display("FAIL rstmid_regs byte=%h crc=%h exp=00/0000", data_byte, crc_calc); end
    repeat (40) send_bit(1'b1);
    checks++; if (stb_q.size() != 100 || done_cnt != 0) begin failures++;
      $display("FAIL rstmid_quiet stb=%0d done=%0d exp=100/0", stb_q.size(), done_cnt); end
    send_block(10'd1, 1, 8'hFF, -1, 16'h1EF0, 1'b1);
    checks++; if (crc_ok !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL rstmid_recover crc_ok=%b done=%0d exp=1/1", crc_ok, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_single_ff_start_ignored();
    test_full_block();
    test_crc_error();
    test_end_error();
    test_timeout();
    test_abort();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
